// File: rtl/l1_coh_req_pkg.sv
// Shared coherence-link types for the L1 request initiator.
package coh_types;

  typedef enum logic [2:0] {
    GETS      = 3'd0,
    GETM      = 3'd1,
    PUTM      = 3'd2,
    DATA      = 3'd3,
    DATA_EXCL = 3'd4
  } coh_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WB_ISSUE  = 3'd1,
    S_REQ_ISSUE = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_FILL      = 3'd4
  } l1_req_state_t;

  localparam int unsigned LINE_BYTES_DEF = 32;
  localparam int unsigned LINE_OFF_W_DEF = $clog2(LINE_BYTES_DEF);

  function automatic int unsigned line_off_w(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/l1_coh_wdog.sv
// Response watchdog: counts cycles while active and flags expiry at TIMEOUT_CYC.
module l1_coh_wdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  assign expire = active && (cnt >= CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (!active || expire) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/l1_coh_req.sv
// L1 coherence initiator: one MSHR plus one writeback slot, GETS/GETM/PUTM out, fills back.
// Optional response watchdog enabled by defining L1_COH_TIMEOUT_EN.
module l1_coh_req
  import coh_types::*;
#(
  parameter int unsigned CORE_ID     = 0,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_BYTES  = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_valid,
  output logic                    miss_ready,
  input  logic                    miss_write,
  input  logic [ADDR_W-1:0]       miss_addr,
  input  logic                    victim_dirty,
  input  logic [ADDR_W-1:0]       victim_addr,
  input  logic [LINE_BYTES*8-1:0] victim_line,
  output logic                    fill_valid,
  output logic                    fill_excl,
  output logic [ADDR_W-1:0]       fill_addr,
  output logic [LINE_BYTES*8-1:0] fill_line,
  output logic                    req_valid,
  input  logic                    req_ready,
  output coh_cmd_t                req_cmd,
  output logic [ADDR_W-1:0]       req_addr,
  output logic [LINE_BYTES*8-1:0] req_line,
  input  logic                    resp_valid,
  input  coh_cmd_t                resp_cmd,
  input  logic [1:0]              resp_dst,
  input  logic [LINE_BYTES*8-1:0] resp_line,
  output logic                    proto_err,
  output logic                    busy
);

  localparam int unsigned LINE_W   = LINE_BYTES * 8;
  localparam int unsigned OFF_W    = line_off_w(LINE_BYTES);
  localparam logic [1:0]  CORE_DST = 2'(CORE_ID);

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r            = a;
    r[OFF_W-1:0] = '0;
    return r;
  endfunction

  l1_req_state_t     state_q, state_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q, vaddr_q;
  logic [LINE_W-1:0] vline_q;

  logic              hs, dst_hit, resp_ok, accept, err_d, tmo;
  logic              src_write;
  logic [ADDR_W-1:0] src_addr, src_vaddr;
  logic [LINE_W-1:0] src_vline;
  logic              req_valid_d;
  coh_cmd_t          req_cmd_d;
  logic [ADDR_W-1:0] req_addr_d;
  logic [LINE_W-1:0] req_line_d;

  assign miss_ready = !rst && (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign hs         = miss_valid && miss_ready;
  assign dst_hit    = resp_valid && (resp_dst == CORE_DST);
  assign resp_ok    = (resp_cmd == DATA_EXCL) || (resp_cmd == DATA && !write_q);

`ifdef L1_COH_TIMEOUT_EN
  l1_coh_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .active (state_q == S_WAIT_RESP),
    .expire (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  // Payload sources bypass the capture registers on the handshake cycle so the
  // registered request appears one cycle after the miss is accepted.
  assign src_write = hs ? miss_write               : write_q;
  assign src_addr  = hs ? align(miss_addr)         : addr_q;
  assign src_vaddr = hs ? align(victim_addr)       : vaddr_q;
  assign src_vline = hs ? victim_line              : vline_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE:      if (hs) state_d = victim_dirty ? S_WB_ISSUE : S_REQ_ISSUE;
      S_WB_ISSUE:  if (req_ready) state_d = S_REQ_ISSUE;
      S_REQ_ISSUE: if (req_ready) state_d = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (dst_hit && resp_ok) begin
          accept  = 1'b1;
          state_d = S_FILL;
        end else begin
          if (dst_hit) err_d = 1'b1;
          if (tmo) begin
            err_d   = 1'b1;
            state_d = S_REQ_ISSUE;
          end
        end
      end
      S_FILL:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (dst_hit && state_q != S_WAIT_RESP) err_d = 1'b1;
  end

  always_comb begin
    req_valid_d = 1'b0;
    req_cmd_d   = GETS;
    req_addr_d  = '0;
    req_line_d  = '0;
    if (state_d == S_WB_ISSUE) begin
      req_valid_d = 1'b1;
      req_cmd_d   = PUTM;
      req_addr_d  = src_vaddr;
      req_line_d  = src_vline;
    end else if (state_d == S_REQ_ISSUE) begin
      req_valid_d = 1'b1;
      req_cmd_d   = src_write ? GETM : GETS;
      req_addr_d  = src_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      vaddr_q    <= '0;
      vline_q    <= '0;
      req_valid  <= 1'b0;
      req_cmd    <= GETS;
      req_addr   <= '0;
      req_line   <= '0;
      fill_valid <= 1'b0;
      fill_excl  <= 1'b0;
      fill_addr  <= '0;
      fill_line  <= '0;
      proto_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_valid  <= req_valid_d;
      req_cmd    <= req_cmd_d;
      req_addr   <= req_addr_d;
      req_line   <= req_line_d;
      proto_err  <= err_d;
      fill_valid <= accept;
      if (hs) begin
        write_q <= miss_write;
        addr_q  <= align(miss_addr);
        vaddr_q <= align(victim_addr);
        vline_q <= victim_line;
      end
      if (accept) begin
        fill_excl <= (resp_cmd == DATA_EXCL);
        fill_addr <= addr_q;
        fill_line <= resp_line;
      end
    end
  end

endmodule

// File: doc/l1_coh_req.md
Name: l1_coh_req

Overview:
- Per-core L1-side coherence initiator: converts L1 miss/eviction events into GETS/GETM/PUTM requests on the coherence link and returns DATA/DATA_EXCL fills to the L1.
- One instance per core, sitting between the L1 cache controller and its link to the L2 directory.
- Single outstanding miss (one MSHR) plus a one-entry writeback slot for the dirty victim.

Parameters:
- CORE_ID, 0, this core's index; only responses whose dst equals it are consumed.
- ADDR_W, 32, address width.
- LINE_BYTES, 32, line size; LINE_W = LINE_BYTES*8.
- TIMEOUT_CYC, 1024, watchdog limit (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- miss_valid  in  1  L1 miss request
- miss_ready  out  1  block can accept a miss
- miss_write  in  1  1 = store miss/upgrade (GETM), 0 = load miss (GETS)
- miss_addr  in  ADDR_W  miss address (any byte offset)
- victim_dirty  in  1  victim must be written back (PUTM)
- victim_addr  in  ADDR_W  victim line address
- victim_line  in  LINE_W  victim data
- fill_valid  out  1  one-cycle fill pulse to L1
- fill_excl  out  1  fill granted M permission
- fill_addr  out  ADDR_W  line-aligned fill address
- fill_line  out  LINE_W  fill data
- req_valid  out  1  link request valid
- req_ready  in  1  directory accepts request
- req_cmd  out  coh_cmd_t  GETS/GETM/PUTM
- req_addr  out  ADDR_W  line-aligned request address
- req_line  out  LINE_W  PUTM data (zero otherwise)
- resp_valid  in  1  link response valid
- resp_cmd  in  coh_cmd_t  DATA/DATA_EXCL
- resp_dst  in  2  destination core
- resp_line  in  LINE_W  response data
- proto_err  out  1  one-cycle pulse on unexpected response
- busy  out  1  FSM not IDLE

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; miss_ready = 0 while rst is high, then 1 in IDLE.
- miss_ready = (state == IDLE). Miss handshake: miss_valid & miss_ready. On handshake, capture miss_addr with its low log2(LINE_BYTES) bits cleared, miss_write, victim_dirty, victim_addr (aligned), and victim_line.
- FSM states:
  - IDLE: on handshake go to WB_ISSUE if victim_dirty, else REQ_ISSUE.
  - WB_ISSUE: req_valid = 1, req_cmd = PUTM, req_addr = victim address, req_line = victim data. On req_ready go to REQ_ISSUE. PUTM has no response.
  - REQ_ISSUE: req_valid = 1, req_cmd = GETM if write else GETS, req_line = 0. On req_ready go to WAIT_RESP.
  - WAIT_RESP: when resp_valid & resp_dst == CORE_ID:
    - GETS accepts DATA (fill_excl = 0) or DATA_EXCL (fill_excl = 1).
    - GETM accepts DATA_EXCL only.
    - On accept: latch the line and go to FILL.
    - Any other cmd: proto_err pulse, stay in WAIT_RESP.
  - FILL: fill_valid = 1 for exactly one cycle with latched addr/line/excl, then IDLE.
- All request outputs are registered. req_valid holds stable with constant payload until req_ready; no retraction.
- Latency, zero-wait link: handshake at cycle 0 → req_valid at cycle 1; response at cycle N → fill_valid at N+1 → miss_ready high at N+2.
- resp_valid with resp_dst == CORE_ID in any state other than WAIT_RESP: ignored, proto_err pulses. resp_dst ≠ CORE_ID: always ignored silently.
- Response in the same cycle the GET is accepted (REQ_ISSUE & req_ready): treated as an unexpected response (proto_err); the directory responds no earlier than the next cycle.
- Reset mid-transaction: outstanding request abandoned, state to IDLE, no fill produced.

Optional Feature:
- Macro L1_COH_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT_RESP and increments each cycle in it. On reaching TIMEOUT_CYC, proto_err pulses, the FSM reissues the same GET (returns to REQ_ISSUE), and the counter clears.
- Undefined: no counter; WAIT_RESP waits indefinitely.

Decomposition:
- coh_types package holds coh_cmd_t (GETS, GETM, PUTM, DATA, DATA_EXCL) plus a new l1_req_state_t enum and the LINE_BYTES-derived offset-width constant.
- Sub-module: l1_coh_wdog (timeout counter), instantiated only under L1_COH_TIMEOUT_EN.

Test Plan:
- Load miss, clean victim: miss_addr=0x0000_1234, miss_write=0, directory answers DATA line=0xA5.. after 3 cycles → one GETS at addr 0x0000_1220; fill_valid 1 cycle, fill_excl=0, fill_line=0xA5..
- Store miss, dirty victim 0x0000_8040 with line=0x5A..: PUTM at 0x0000_8040 with req_line=0x5A.. precedes GETM; DATA_EXCL → fill_excl=1.
- req_ready held low 5 cycles → req_valid/req_cmd/req_addr stable for all 5 cycles; exactly one request accepted.
- In WAIT_RESP after GETM: DATA with dst=CORE_ID → proto_err pulse, no fill; DATA with dst≠CORE_ID → no error; then DATA_EXCL → fill.
- Assert rst during WAIT_RESP, then deliver a response → no fill_valid, proto_err pulses, miss_ready=1.
- With L1_COH_TIMEOUT_EN and TIMEOUT_CYC=16: no response → proto_err at cycle 16 of wait and GETS reissued to the same address.
